// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: programmable window sequencer for the 3-bit counter datapath.
// Steps q through [lo, hi] in up, down or bounce order for a set number of rounds.
module count_seq_ctrl #(
    parameter int W  = 3,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic [RW-1:0] rounds,
    output logic [W-1:0]  q,
    output logic          dir,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_UP     = 2'b00;
    localparam logic [1:0] M_DOWN   = 2'b01;
    localparam logic [1:0] M_BOUNCE = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  q_q, q_d;
    logic          dir_q, dir_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [RW-1:0] rounds_q, rounds_d;

    logic illegal;
    logic last;

    assign illegal = (lo > hi) || (mode == 2'b11) ||
                     ((mode == M_BOUNCE) && (lo == hi));

    // rounds == 0 never matches, so the run continues until stop
    assign last = (rounds_q != '0) && (rcnt_q == rounds_q - 1'b1);

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        dir_d    = dir_q;
        rcnt_d   = rcnt_q;
        mode_d   = mode_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        rounds_d = rounds_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d   = mode;
                        lo_d     = lo;
                        hi_d     = hi;
                        rounds_d = rounds;
                        rcnt_d   = '0;
                        state_d  = S_RUN;
                        if (mode == M_DOWN) begin
                            q_d   = hi;
                            dir_d = 1'b1;
                        end else begin
                            q_d   = lo;
                            dir_d = 1'b0;
                        end
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    case (mode_q)
                        M_UP: begin
                            if (q_q != hi_q) begin
                                q_d = q_q + 1'b1;
                            end else if (last) begin
                                state_d = S_DONE;
                            end else begin
                                q_d    = lo_q;
                                rcnt_d = rcnt_q + 1'b1;
                            end
                        end
                        M_DOWN: begin
                            if (q_q != lo_q) begin
                                q_d = q_q - 1'b1;
                            end else if (last) begin
                                state_d = S_DONE;
                            end else begin
                                q_d    = hi_q;
                                rcnt_d = rcnt_q + 1'b1;
                            end
                        end
                        M_BOUNCE: begin
                            if (!dir_q) begin
                                if (q_q != hi_q) begin
                                    q_d = q_q + 1'b1;
                                end else begin
                                    q_d   = hi_q - 1'b1;
                                    dir_d = 1'b1;
                                end
                            end else if (q_q != lo_q) begin
                                q_d = q_q - 1'b1;
                            end else if (last) begin
                                state_d = S_DONE;
                            end else begin
                                q_d    = lo_q + 1'b1;
                                dir_d  = 1'b0;
                                rcnt_d = rcnt_q + 1'b1;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            q_q      <= '0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rcnt_q   <= '0;
            mode_q   <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            rounds_q <= '0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rcnt_q   <= rcnt_d;
            mode_q   <= mode_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            rounds_q <= rounds_d;
        end
    end

    assign q    = q_q;
    assign dir  = dir_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: sequence-queue reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_count_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] lo = 3'd0;
    logic [2:0] hi = 3'd0;
    logic [3:0] rounds = 4'd0;
    logic [2:0] q;
    logic       dir, busy, done, err;

    int compared = 0;
    int mismatched = 0;

    count_seq_ctrl #(.W(3), .RW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .mode(mode), .lo(lo), .hi(hi), .rounds(rounds),
        .q(q), .dir(dir), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: an accepted start expands into the full list of
    // (q, dir) values the run must show; each RUN edge pops one value.
    logic [2:0] m_q = 3'd0;
    logic       m_dir = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    bit         m_inf = 1'b0;
    int         c_mode, c_lo, c_hi;
    int         seq[$];

    task automatic append_round(input bit first);
        int s;
        if (c_mode == 0) begin
            for (int v = c_lo; v <= c_hi; v++) seq.push_back(v);
        end else if (c_mode == 1) begin
            for (int v = c_hi; v >= c_lo; v--) seq.push_back(v + 8);
        end else begin
            s = first ? c_lo : c_lo + 1;
            for (int v = s; v <= c_hi; v++) seq.push_back(v);
            for (int v = c_hi - 1; v >= c_lo; v--) seq.push_back(v + 8);
        end
    endtask

    task automatic pop_val();
        int e;
        e = seq.pop_front();
        m_q = 3'(e % 8);
        m_dir = (e >= 8);
    endtask

    initial forever begin
        bit pd;
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_q = 0; m_dir = 0; m_busy = 0; m_done = 0; m_err = 0;
            m_inf = 0;
            seq.delete();
        end else begin
            pd = m_done;
            m_done = 0;
            m_err = 0;
            if (m_busy) begin
                if (stop) begin
                    m_busy = 0;
                    seq.delete();
                end else begin
                    if (seq.size() == 0 && m_inf) append_round(1'b0);
                    if (seq.size() == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end else begin
                        pop_val();
                    end
                end
            end else if (!pd && start) begin
                if (lo > hi || mode == 2'b11 || (mode == 2'b10 && lo == hi)) begin
                    m_err = 1;
                end else begin
                    c_mode = int'(mode);
                    c_lo = int'(lo);
                    c_hi = int'(hi);
                    m_inf = (rounds == 0);
                    seq.delete();
                    for (int r = 0; r < (m_inf ? 1 : int'(rounds)); r++)
                        append_round(r == 0);
                    m_busy = 1;
                    pop_val();
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        compared++;
        if ({q, dir, busy, done, err} !== {m_q, m_dir, m_busy, m_done, m_err}) begin
            mismatched++;
            $display("FAIL model t=%0t: got q=%0d dir=%0b busy=%0b done=%0b err=%0b, want q=%0d dir=%0b busy=%0b done=%0b err=%0b",
                     $time, q, dir, busy, done, err, m_q, m_dir, m_busy, m_done, m_err);
        end
    end

    task automatic chk(input string nm, input logic [2:0] eq, input logic ed,
                       input logic eb, input logic edn, input logic ee);
        compared++;
        if ({q, dir, busy, done, err} !== {eq, ed, eb, edn, ee}) begin
            mismatched++;
            $display("FAIL %s: got q=%0d dir=%0b busy=%0b done=%0b err=%0b, want q=%0d dir=%0b busy=%0b done=%0b err=%0b",
                     nm, q, dir, busy, done, err, eq, ed, eb, edn, ee);
        end
    endtask

    task automatic start_cfg(input logic [1:0] m, input logic [2:0] l,
                             input logic [2:0] h, input logic [3:0] r);
        @(negedge clk);
        mode = m; lo = l; hi = h; rounds = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int expq[$];

    // Walk the expected values, then check the done pulse and return to idle.
    task automatic run_seq(input string nm, input bit poke);
        int e;
        for (int i = 0; i < expq.size(); i++) begin
            if (i > 0) @(negedge clk);
            e = expq[i];
            chk(nm, 3'(e % 8), e >= 8, 1'b1, 1'b0, 1'b0);
            if (poke && i == 2) begin
                start = 1'b1; mode = 2'b00; lo = 3'd0; hi = 3'd7; rounds = 4'd0;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk({nm, "_done"}, 3'(e % 8), e >= 8, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk({nm, "_idle"}, 3'(e % 8), e >= 8, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic illegal(input string nm, input logic [1:0] m,
                           input logic [2:0] l, input logic [2:0] h);
        start_cfg(m, l, h, 4'd1);
        chk(nm, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk({nm, "_after"}, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; mode = 2'b00; lo = 3'd3; hi = 3'd5; rounds = 4'd1;
        repeat (3) @(negedge clk);
        chk("reset_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        start_cfg(2'b00, 3'd2, 3'd5, 4'd1);
        expq = '{2, 3, 4, 5};
        run_seq("up_2_5", 1'b0);

        start_cfg(2'b01, 3'd1, 3'd6, 4'd2);
        expq = '{14, 13, 12, 11, 10, 9, 14, 13, 12, 11, 10, 9};
        run_seq("down_1_6", 1'b1);

        start_cfg(2'b10, 3'd1, 3'd3, 4'd2);
        expq = '{1, 2, 3, 10, 9, 2, 3, 10, 9};
        run_seq("bounce_1_3", 1'b0);

        illegal("ill_lo_gt_hi", 2'b00, 3'd5, 3'd2);
        illegal("ill_mode11", 2'b11, 3'd1, 3'd6);
        illegal("ill_bounce_eq", 2'b10, 3'd4, 3'd4);

        start_cfg(2'b00, 3'd0, 3'd7, 4'd0);
        repeat (4) @(negedge clk);
        chk("abort_pre", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("abort_hold", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("abort_nodone", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);

        start_cfg(2'b00, 3'd0, 3'd7, 4'd0);
        repeat (3) @(negedge clk);
        chk("rst_pre", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 chk("async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        repeat (4000) begin
            @(negedge clk);
            reset  = ($urandom_range(0, 299) != 0);
            start  = ($urandom_range(0, 3) == 0);
            stop   = ($urandom_range(0, 15) == 0);
            mode   = 2'($urandom_range(0, 3));
            lo     = 3'($urandom_range(0, 7));
            hi     = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(int'(lo), 7))
                                                 : 3'($urandom_range(0, 7));
            rounds = 4'($urandom_range(0, 3));
        end
        @(negedge clk);
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
